spi_host: RTL and testbench
===========================

# spi_host

SPI initiator that drives the on-chip `SPI` configuration/readback slave from the host side. One full-duplex frame:
- shifts a 64-bit write word into the slave's `R` register on `MOSI`;
- captures the slave's 48-bit `RD` readback from `MISO`.

It is used in the FPGA test harness and bench as the board-side controller. It will also serve as the on-chip master for future multi-die configurations. Frames are launched by a single-cycle start/done handshake.

## Interface
Parameters:
- `HALF`, default 2: SCLK half-period in CLK cycles, minimum 1.
- `W_BITS`, default 64: frame length and write-word width; matches slave `R`.
- `R_BITS`, default 48: readback width, `R_BITS <= W_BITS`; matches slave `RD`.

Ports:
- `CLK` in 1: system clock; all logic on the rising edge.
- `RST` in 1: asynchronous, active-low reset.
- `start` in 1: launch a frame; sampled only in IDLE.
- `wdata` in W_BITS: write word; latched on the accepted `start`.
- `busy` out 1: frame in progress, including the CEB-high gap.
- `done` out 1: one-cycle pulse at end of frame; `rdata` is valid from this cycle.
- `rdata` out R_BITS: captured readback; holds until the next `done`.
- `SCLK` out 1: SPI clock, idle low (mode 0).
- `CEB` out 1: chip enable, active low.
- `MOSI` out 1: serial data to the slave `DATA` input.
- `MISO` in 1: serial data from the slave `DOUT_DAT` output.

## Operation
- States: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE:
  - `start=1` latches `wdata` into the shift register.
  - Next cycle: SETUP, with `CEB=0`, `MOSI=wdata[W_BITS-1]` and `busy=1`.
- SETUP: wait HALF cycles, then raise SCLK and enter SHIFT.
- SHIFT:
  - SCLK toggles every HALF cycles.
  - On each SCLK rise, `MISO` is shifted into the capture register.
  - On each SCLK fall, `MOSI` advances to the next lower bit.
  - Bit counter 0..W_BITS-1 counts rises. After the rise for bit W_BITS-1 and its following fall, go to HOLD.
- HOLD: SCLK low for HALF cycles, then `CEB=1`, `MOSI=0`, go to GAP.
- GAP: hold CEB high for HALF cycles, then pulse `done` for one cycle, drop `busy`, return to IDLE.
- Write order is MSB first: `MOSI` carries `wdata[W_BITS-1]` down to `wdata[0]`.
- Read order: `rdata = {first R_BITS MISO samples}`, MSB first. The first sample lands in `rdata[R_BITS-1]`. Samples R_BITS..W_BITS-1 are discarded.
- `rdata` is loaded from the capture register in the cycle `done` is asserted.
- `start` while busy is ignored; no queueing.
- `wdata` changes after acceptance have no effect on the frame in flight.
- Bit counter width is `$clog2(W_BITS)`; the half-period counter width is `$clog2(HALF)+1`. Neither counter wraps inside a frame.

## Timing
- Reset values: `CEB=1`, `SCLK=0`, `MOSI=0`, `busy=0`, `done=0`, `rdata=0`, state IDLE.
- Reset mid-frame: CEB returns high asynchronously and the frame is abandoned. No `done` pulse; `rdata` is cleared.
- Cycle numbering: cycle 0 is the cycle `start` is sampled high in IDLE.
  - `CEB` falls at cycle 1.
  - Rise of bit k (k = 0..W_BITS-1) at cycle `1+HALF+2*HALF*k`.
  - Fall of bit k at cycle `1+2*HALF*(k+1)`.
  - `CEB` rises at cycle `1+(2*W_BITS+1)*HALF`.
  - `done` and `busy` falling at cycle `1+(2*W_BITS+2)*HALF`.
  - Defaults (HALF=2, 64 bits): CEB low at 1, CEB high at 259, `done` at 261.
- MISO sample point: the value present on the CLK edge that drives SCLK high. This gives the slave HALF cycles of setup after its falling-edge update.
- MOSI setup/hold to SCLK rise is HALF cycles each.
- Back-to-back frames: `start` in the `done` cycle is ignored, since the block is not yet in IDLE. `start` one cycle after `done` is accepted.
- Minimum CEB-high time between frames: HALF+2 cycles.

## Structure
- Shared package `spi_pkg`:
  - `SPI_W_BITS=64`, `SPI_R_BITS=48`, `SPI_ID=16'h55AA`;
  - state enum `spi_host_state_t`.
- The same package is reused by the bench slave model.
- One sub-module, `spi_host_tick`: half-period counter emitting a one-cycle `tick` every HALF cycles, restarted by `start`.
- The FSM, shift register and capture register live in `spi_host`.

## Test plan
- Reset mid-frame: assert `RST` low at cycle 100 -> CEB=1 and SCLK=0 immediately, `rdata=0`, no `done` pulse. After release, a new frame completes normally.
- Readback ID: slave model with `RD=48'h0000_55AA_0000` -> `rdata=48'h0000_55AA_0000` at `done`. `RD[31:16]` carries the fixed 0x55AA tie-off pattern.
- Write word: `wdata=64'hDEAD_BEEF_0123_4567` -> slave `R` equals that value after CEB rises. The first MOSI bit is 1 (MSB).
- Cycle count (HALF=2): `start` at cycle 0 -> CEB low at 1, 64 SCLK rises, CEB high at 259, `done` at 261 for exactly one cycle.
- Start-while-busy and back-to-back: pulse `start` at cycles 50 and 261 -> both ignored. `start` at 262 -> the second frame's CEB falls at 263.
- HALF=1 build: all-ones write, alternating `1010…` MISO -> `rdata=48'hAAAA_AAAA_AAAA`, `done` at cycle 131.

Source files
------------

// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared constants and types for the SPI host and the slave it talks to.
//   SPI_W_BITS : write-frame length (slave R register width)
//   SPI_R_BITS : readback width (slave RD register width)
//   SPI_ID     : fixed tie-off pattern the slave returns in RD[31:16]
// -----------------------------------------------------------------------------
package spi_pkg;

    localparam int          SPI_W_BITS = 64;
    localparam int          SPI_R_BITS = 48;
    localparam logic [15:0] SPI_ID     = 16'h55AA;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } spi_host_state_t;

endpackage

// File: rtl/spi_host_tick.sv
// -----------------------------------------------------------------------------
// spi_host_tick
// Half-period timer for the SPI host. Emits a one-cycle tick every HALF clock
// cycles; restart zeroes the count so the first tick lands exactly HALF cycles
// after the restart cycle.
//   clk     in  : system clock
//   rst_n   in  : asynchronous active-low reset
//   restart in  : zero the count (frame accepted)
//   tick    out : one-cycle pulse every HALF cycles
// -----------------------------------------------------------------------------
module spi_host_tick #(
    parameter int HALF = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int            CW   = $clog2(HALF) + 1;
    localparam logic [CW-1:0] LAST = CW'(HALF - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_host.sv
// -----------------------------------------------------------------------------
// spi_host
// Mode-0 SPI initiator: one full-duplex frame shifts W_BITS of wdata out on
// MOSI (MSB first) and captures the first R_BITS MISO samples into rdata.
//   CLK   in  : system clock
//   RST   in  : asynchronous active-low reset
//   start in  : launch a frame (sampled only in IDLE)
//   wdata in  : write word, latched on the accepted start
//   busy  out : frame in progress, including the CEB-high gap
//   done  out : one-cycle end-of-frame pulse; rdata valid from this cycle
//   rdata out : captured readback, held until the next done
//   SCLK  out : SPI clock, idle low
//   CEB   out : chip enable, active low
//   MOSI  out : serial data to slave
//   MISO  in  : serial data from slave
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | CEB high, waiting for start
// ST_SETUP | CEB low, first MOSI bit set up for HALF cycles
// ST_SHIFT | SCLK toggling; sample MISO on rise, advance MOSI on fall
// ST_HOLD  | SCLK low after last fall, CEB still low for HALF cycles
// ST_GAP   | CEB high for HALF cycles, then done pulse
// -----------------------------------------------------------------------------
module spi_host
    import spi_pkg::*;
#(
    parameter int HALF   = 2,
    parameter int W_BITS = SPI_W_BITS,
    parameter int R_BITS = SPI_R_BITS
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [W_BITS-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [R_BITS-1:0] rdata,
    output logic              SCLK,
    output logic              CEB,
    output logic              MOSI,
    input  logic              MISO
);

    localparam int            BW       = $clog2(W_BITS);
    localparam logic [BW-1:0] BIT_LAST = BW'(W_BITS - 1);

    spi_host_state_t   state_q, state_d;
    logic [W_BITS-1:0] sr_q, sr_d;
    logic [R_BITS-1:0] cap_q, cap_d;
    logic [R_BITS-1:0] rdata_q, rdata_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic              sclk_q, sclk_d;
    logic              ceb_q, ceb_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic accept;
    logic tick;

    assign accept = (state_q == ST_IDLE) && start;

    spi_host_tick #(
        .HALF (HALF)
    ) u_tick (
        .clk     (CLK),
        .rst_n   (RST),
        .restart (accept),
        .tick    (tick)
    );

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cap_d   = cap_q;
        rdata_d = rdata_q;
        bit_d   = bit_q;
        sclk_d  = sclk_q;
        ceb_d   = ceb_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SETUP;
                    sr_d    = wdata;
                    cap_d   = '0;
                    bit_d   = '0;
                    ceb_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            ST_SETUP: begin
                if (tick) begin
                    state_d = ST_SHIFT;
                    sclk_d  = 1'b1;
                    cap_d   = R_BITS'({cap_q, MISO});
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                        sr_d   = sr_q << 1;
                        if (bit_q == BIT_LAST) begin
                            state_d = ST_HOLD;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        sclk_d = 1'b1;
                        // Samples beyond the readback width are dropped so the
                        // first MISO bit stays at the top of rdata.
                        if (32'(bit_q) < R_BITS) begin
                            cap_d = R_BITS'({cap_q, MISO});
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    state_d = ST_GAP;
                    ceb_d   = 1'b1;
                    sr_d    = '0;
                end
            end
            ST_GAP: begin
                // The done cycle is still GAP so a start coinciding with done
                // is not accepted; IDLE is reached one cycle later.
                if (done_q) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    rdata_d = cap_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            cap_q   <= '0;
            rdata_q <= '0;
            bit_q   <= '0;
            sclk_q  <= 1'b0;
            ceb_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cap_q   <= cap_d;
            rdata_q <= rdata_d;
            bit_q   <= bit_d;
            sclk_q  <= sclk_d;
            ceb_q   <= ceb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign SCLK  = sclk_q;
    assign CEB   = ceb_q;
    assign MOSI  = sr_q[W_BITS-1];
    assign busy  = busy_q;
    assign done  = done_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_spi_host.sv
// -----------------------------------------------------------------------------
// tb_spi_host
// Bench for spi_host: a behavioural SPI slave on each DUT instance, random and
// directed frames, cycle-timing checks, reset mid-frame and a HALF=1 build.
// -----------------------------------------------------------------------------
module tb_spi_host;
    import spi_pkg::*;

    localparam int HALF = 2;
    localparam int W    = SPI_W_BITS;
    localparam int R    = SPI_R_BITS;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // ---------------- instance 0 : HALF=2 ----------------
    logic         start = 1'b0;
    logic [W-1:0] wdata = '0;
    logic         busy, done, SCLK, CEB, MOSI, MISO;
    logic [R-1:0] rdata;

    spi_host #(.HALF(HALF), .W_BITS(W), .R_BITS(R)) u_dut (
        .CLK(CLK), .RST(RST), .start(start), .wdata(wdata),
        .busy(busy), .done(done), .rdata(rdata),
        .SCLK(SCLK), .CEB(CEB), .MOSI(MOSI), .MISO(MISO)
    );

    // ---------------- instance 1 : HALF=1 ----------------
    logic         start1 = 1'b0;
    logic [W-1:0] wdata1 = '0;
    logic         busy1, done1, SCLK1, CEB1, MOSI1, MISO1;
    logic [R-1:0] rdata1;

    spi_host #(.HALF(1), .W_BITS(W), .R_BITS(R)) u_dut1 (
        .CLK(CLK), .RST(RST), .start(start1), .wdata(wdata1),
        .busy(busy1), .done(done1), .rdata(rdata1),
        .SCLK(SCLK1), .CEB(CEB1), .MOSI(MOSI1), .MISO(MISO1)
    );

    // ---------------- slave models (mode 0) ----------------
    // Slave drives RD MSB first: first bit valid while CEB low, next bit after
    // each SCLK fall; it shifts MOSI into R on each SCLK rise.
    logic [R-1:0] s0_rd = '0;
    logic [W-1:0] s0_r  = '0;
    int           s0_idx = 0, s0_rises = 0;

    always @(negedge CEB) begin s0_idx = 0; s0_rises = 0; end
    always @(negedge SCLK) if (!CEB) s0_idx++;
    always @(posedge SCLK) if (!CEB) begin s0_r = {s0_r[W-2:0], MOSI}; s0_rises++; end
    assign MISO = (!CEB && s0_idx < R) ? s0_rd[R-1-s0_idx] : 1'b0;

    logic [R-1:0] s1_rd = '0;
    logic [W-1:0] s1_r  = '0;
    int           s1_idx = 0, s1_rises = 0;

    always @(negedge CEB1) begin s1_idx = 0; s1_rises = 0; end
    always @(negedge SCLK1) if (!CEB1) s1_idx++;
    always @(posedge SCLK1) if (!CEB1) begin s1_r = {s1_r[W-2:0], MOSI1}; s1_rises++; end
    assign MISO1 = (!CEB1 && s1_idx < R) ? s1_rd[R-1-s1_idx] : 1'b0;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int model_ceb_rise(input int half, input int wb);
        return 1 + (2 * wb + 1) * half;
    endfunction

    function automatic int model_done(input int half, input int wb);
        return 1 + (2 * wb + 2) * half;
    endfunction

    // Build the MISO bit stream the slave emits over a whole frame, then keep
    // the first R samples, first sample most significant.
    function automatic logic [R-1:0] model_rdata(input logic [R-1:0] rd);
        bit           stream[$];
        logic [R-1:0] res = '0;
        for (int i = 0; i < W; i++) stream.push_back((i < R) ? rd[R-1-i] : 1'b0);
        for (int i = 0; i < R; i++) res = {res[R-2:0], stream[i]};
        return res;
    endfunction

    // Called at a negedge; drives start at that negedge (cycle 0) and returns
    // at the negedge one cycle after done dropped.
    task automatic run_frame(input logic [W-1:0] w, input logic [R-1:0] rd,
                             input int pa, input int pb,
                             output int ceb_fall, output int ceb_rise,
                             output int done_cyc, output int done_len,
                             output logic [R-1:0] rd_at_done, output logic first_mosi);
        int s;
        int rel;
        ceb_fall = -1; ceb_rise = -1; done_cyc = -1; done_len = 0;
        rd_at_done = '0; first_mosi = 1'b0;
        s0_rd = rd;
        start = 1'b1;
        wdata = w;
        s = cyc;
        for (int i = 0; i < 2000; i++) begin
            @(negedge CLK);
            rel   = cyc - s;
            start = (rel == pa) || (rel == pb);
            wdata = {$urandom, $urandom};
            if (rel == 1) first_mosi = MOSI;
            if (!CEB && ceb_fall < 0) ceb_fall = rel;
            if (CEB && ceb_fall >= 0 && ceb_rise < 0) ceb_rise = rel;
            if (done) begin
                if (done_cyc < 0) begin
                    done_cyc   = rel;
                    rd_at_done = rdata;
                end
                done_len++;
            end
            if (done_cyc >= 0 && !done) break;
        end
        start = 1'b0;
        check("frame_completed", 64'(done_cyc >= 0), 64'd1);
    endtask

    task automatic check_frame(input string tag, input logic [W-1:0] w, input logic [R-1:0] rd,
                               input int ceb_fall, input int ceb_rise,
                               input int done_cyc, input int done_len,
                               input logic [R-1:0] rd_at_done, input logic first_mosi);
        check({tag, "_ceb_fall"},   64'(ceb_fall),  64'd1);
        check({tag, "_ceb_rise"},   64'(ceb_rise),  64'(model_ceb_rise(HALF, W)));
        check({tag, "_done_cyc"},   64'(done_cyc),  64'(model_done(HALF, W)));
        check({tag, "_done_len"},   64'(done_len),  64'd1);
        check({tag, "_rdata"},      64'(rd_at_done), 64'(model_rdata(rd)));
        check({tag, "_slave_r"},    s0_r,           w);
        check({tag, "_rises"},      64'(s0_rises),  64'(W));
        check({tag, "_first_mosi"}, 64'(first_mosi), 64'(w[W-1]));
    endtask

    initial begin
        logic [W-1:0] w;
        logic [R-1:0] rd;
        logic [R-1:0] rd_at_done;
        logic         first_mosi;
        int           cf, cr, dc, dl;
        int           s, rel, n_done;

        // ---- reset values ----
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_ceb",   64'(CEB),   64'd1);
        check("rst_sclk",  64'(SCLK),  64'd0);
        check("rst_mosi",  64'(MOSI),  64'd0);
        check("rst_busy",  64'(busy),  64'd0);
        check("rst_done",  64'(done),  64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
        RST = 1'b1;
        repeat (2) @(negedge CLK);

        // ---- directed: ID readback, known write word, start while busy ----
        w  = 64'hDEAD_BEEF_0123_4567;
        rd = {16'h0000, SPI_ID, 16'h0000};
        run_frame(w, rd, 50, model_done(HALF, W), cf, cr, dc, dl, rd_at_done, first_mosi);
        check_frame("id", w, rd, cf, cr, dc, dl, rd_at_done, first_mosi);
        check("id_rdata_const", 64'(rd_at_done), 64'h0000_55AA_0000);
        check("start_in_done_ignored_ceb",  64'(CEB),  64'd1);
        check("start_in_done_ignored_busy", 64'(busy), 64'd0);

        // ---- back-to-back: start one cycle after done ----
        w  = {$urandom, $urandom};
        rd = {16'($urandom), $urandom};
        run_frame(w, rd, -1, -1, cf, cr, dc, dl, rd_at_done, first_mosi);
        check_frame("b2b", w, rd, cf, cr, dc, dl, rd_at_done, first_mosi);

        // ---- random frames ----
        for (int f = 0; f < 6; f++) begin
            repeat ($urandom_range(0, 3)) @(negedge CLK);
            w  = {$urandom, $urandom};
            rd = {16'($urandom), $urandom};
            run_frame(w, rd, -1, -1, cf, cr, dc, dl, rd_at_done, first_mosi);
            check_frame("rand", w, rd, cf, cr, dc, dl, rd_at_done, first_mosi);
        end

        // ---- reset mid-frame at cycle 100 ----
        @(negedge CLK);
        check("pre_reset_rdata_nonzero", 64'(rdata != '0), 64'd1);
        s0_rd = {16'($urandom), $urandom};
        start = 1'b1;
        wdata = {$urandom, $urandom};
        s = cyc;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            rel   = cyc - s;
            start = 1'b0;
            if (rel == 100) break;
        end
        check("pre_reset_in_frame", 64'(!CEB && busy), 64'd1);
        RST = 1'b0;
        #1;
        check("midrst_ceb",   64'(CEB),   64'd1);
        check("midrst_sclk",  64'(SCLK),  64'd0);
        check("midrst_rdata", 64'(rdata), 64'd0);
        check("midrst_busy",  64'(busy),  64'd0);
        n_done = 0;
        repeat (3) begin
            @(negedge CLK);
            if (done) n_done++;
        end
        RST = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            if (done) n_done++;
        end
        check("midrst_no_done", 64'(n_done), 64'd0);
        check("midrst_idle_ceb", 64'(CEB), 64'd1);

        w  = {$urandom, $urandom};
        rd = {16'($urandom), $urandom};
        run_frame(w, rd, -1, -1, cf, cr, dc, dl, rd_at_done, first_mosi);
        check_frame("post_rst", w, rd, cf, cr, dc, dl, rd_at_done, first_mosi);

        // ---- HALF=1 build: all-ones write, alternating MISO ----
        @(negedge CLK);
        s1_rd  = 48'hAAAA_AAAA_AAAA;
        start1 = 1'b1;
        wdata1 = '1;
        s  = cyc;
        dc = -1;
        rd_at_done = '0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge CLK);
            rel    = cyc - s;
            start1 = 1'b0;
            wdata1 = {$urandom, $urandom};
            if (done1 && dc < 0) begin
                dc = rel;
                rd_at_done = rdata1;
            end
            if (dc >= 0 && !done1) break;
        end
        check("h1_done_cyc", 64'(dc), 64'(model_done(1, W)));
        check("h1_done_131", 64'(dc), 64'd131);
        check("h1_rdata",    64'(rd_at_done), 64'(model_rdata(48'hAAAA_AAAA_AAAA)));
        check("h1_slave_r",  s1_r, {W{1'b1}});
        check("h1_rises",    64'(s1_rises), 64'(W));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
